// File: rtl/cycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sequencer_pkg
// Purpose  : Shared types and timing constants for the instruction cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cycle_sequencer_pkg;

    localparam int         CYCLE_W    = 3;
    localparam logic [7:0] BRK_OPCODE = 8'h00;

    typedef logic [CYCLE_W-1:0] cycle_t;

    localparam cycle_t CYCLE_MAX = '1;

    typedef enum logic [4:0] {
        GRP_IMPLIED,
        GRP_ZP,
        GRP_ZP_IDX,
        GRP_ABS,
        GRP_IND_X,
        GRP_ABS_IDX_RD,
        GRP_ABS_IDX_WR,
        GRP_IND_Y_RD,
        GRP_IND_Y_WR,
        GRP_RMW_ZP,
        GRP_RMW_ZPX,
        GRP_RMW_ABS,
        GRP_RMW_ABSX,
        GRP_PUSH,
        GRP_PULL,
        GRP_JMP_ABS,
        GRP_JMP_IND,
        GRP_SUBR,
        GRP_BRK,
        GRP_BRANCH
    } addr_grp_e;

    localparam cycle_t LAST_1 = 3'd1;
    localparam cycle_t LAST_2 = 3'd2;
    localparam cycle_t LAST_3 = 3'd3;
    localparam cycle_t LAST_4 = 3'd4;
    localparam cycle_t LAST_5 = 3'd5;
    localparam cycle_t LAST_6 = 3'd6;

    localparam cycle_t FIXUP_ABS_IDX = 3'd3;
    localparam cycle_t FIXUP_IND_Y   = 3'd4;

    typedef enum logic [1:0] {
        INT_NONE  = 2'b00,
        INT_IRQ   = 2'b01,
        INT_NMI   = 2'b10,
        INT_RESET = 2'b11
    } int_src_e;

    // Branches report their worst case; their real end is resolved at run time.
    function automatic cycle_t grp_last(input addr_grp_e grp);
        case (grp)
            GRP_ZP, GRP_PUSH, GRP_JMP_ABS:                   return LAST_2;
            GRP_ZP_IDX, GRP_ABS, GRP_PULL, GRP_BRANCH:       return LAST_3;
            GRP_ABS_IDX_RD, GRP_ABS_IDX_WR, GRP_RMW_ZP,
            GRP_JMP_IND:                                     return LAST_4;
            GRP_IND_X, GRP_IND_Y_RD, GRP_IND_Y_WR,
            GRP_RMW_ZPX, GRP_RMW_ABS, GRP_SUBR:              return LAST_5;
            GRP_RMW_ABSX, GRP_BRK:                           return LAST_6;
            default:                                         return LAST_1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sequencer_if
// Purpose  : Bundles the decode inputs and timing outputs of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface cycle_sequencer_if;
    import cycle_sequencer_pkg::*;

    logic [7:0] IR;
    cycle_t     cycle;
    logic       page_cross;
    logic       branch_taken;
    logic       rdy;
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic       I_cycle;
    logic       R_cycle;
    logic       S_cycle;
    logic       force_brk;
    logic [1:0] int_src;
    logic       sync;

    modport master (
        output IR, cycle, page_cross, branch_taken, rdy, nmi_n, irq_n, i_flag,
        input  I_cycle, R_cycle, S_cycle, force_brk, int_src, sync
    );

    modport slave (
        input  IR, cycle, page_cross, branch_taken, rdy, nmi_n, irq_n, i_flag,
        output I_cycle, R_cycle, S_cycle, force_brk, int_src, sync
    );

endinterface
`default_nettype wire

// File: rtl/cycle_sequencer_opcode_timing_rom.sv
`default_nettype none
// ============================================================================
// Module   : opcode_timing_rom
// Purpose  : Maps an opcode to its addressing group, last cycle and fixup cycle.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_timing_rom
    import cycle_sequencer_pkg::*;
(
    input  logic [7:0] ir_i,
    output addr_grp_e  grp_o,
    output cycle_t     last_o,
    output cycle_t     fixup_o,
    output logic       skip_ok_o
);

    logic [2:0] w_aaa;
    logic [2:0] w_bbb;
    logic [1:0] w_cc;

    assign w_aaa = ir_i[7:5];
    assign w_bbb = ir_i[4:2];
    assign w_cc  = ir_i[1:0];

    always_comb begin
        grp_o = GRP_IMPLIED;
        case (w_cc)
            2'b01: begin
                case (w_bbb)
                    3'b000:  grp_o = GRP_IND_X;
                    3'b001:  grp_o = GRP_ZP;
                    3'b011:  grp_o = GRP_ABS;
                    3'b100:  grp_o = (w_aaa == 3'b100) ? GRP_IND_Y_WR : GRP_IND_Y_RD;
                    3'b101:  grp_o = GRP_ZP_IDX;
                    3'b110,
                    3'b111:  grp_o = (w_aaa == 3'b100) ? GRP_ABS_IDX_WR : GRP_ABS_IDX_RD;
                    default: grp_o = GRP_IMPLIED;
                endcase
            end
            2'b10: begin
                // STX/LDX share the column with the read-modify-write ops.
                if (w_aaa == 3'b100 || w_aaa == 3'b101) begin
                    case (w_bbb)
                        3'b001:  grp_o = GRP_ZP;
                        3'b011:  grp_o = GRP_ABS;
                        3'b101:  grp_o = GRP_ZP_IDX;
                        3'b111:  grp_o = (w_aaa == 3'b101) ? GRP_ABS_IDX_RD : GRP_IMPLIED;
                        default: grp_o = GRP_IMPLIED;
                    endcase
                end else begin
                    case (w_bbb)
                        3'b001:  grp_o = GRP_RMW_ZP;
                        3'b011:  grp_o = GRP_RMW_ABS;
                        3'b101:  grp_o = GRP_RMW_ZPX;
                        3'b111:  grp_o = GRP_RMW_ABSX;
                        default: grp_o = GRP_IMPLIED;
                    endcase
                end
            end
            2'b00: begin
                case (ir_i)
                    BRK_OPCODE:                     grp_o = GRP_BRK;
                    8'h20, 8'h40, 8'h60:            grp_o = GRP_SUBR;
                    8'h08, 8'h48:                   grp_o = GRP_PUSH;
                    8'h28, 8'h68:                   grp_o = GRP_PULL;
                    8'h4C:                          grp_o = GRP_JMP_ABS;
                    8'h6C:                          grp_o = GRP_JMP_IND;
                    8'h24, 8'h84, 8'hA4, 8'hC4,
                    8'hE4:                          grp_o = GRP_ZP;
                    8'h2C, 8'h8C, 8'hAC, 8'hCC,
                    8'hEC:                          grp_o = GRP_ABS;
                    8'h94, 8'hB4:                   grp_o = GRP_ZP_IDX;
                    8'hBC:                          grp_o = GRP_ABS_IDX_RD;
                    default: grp_o = (w_bbb == 3'b100) ? GRP_BRANCH : GRP_IMPLIED;
                endcase
            end
            default: grp_o = GRP_IMPLIED;
        endcase
    end

    always_comb begin
        last_o    = grp_last(grp_o);
        fixup_o   = '0;
        skip_ok_o = 1'b0;
        if (grp_o == GRP_ABS_IDX_RD) begin
            fixup_o   = FIXUP_ABS_IDX;
            skip_ok_o = 1'b1;
        end else if (grp_o == GRP_IND_Y_RD) begin
            fixup_o   = FIXUP_IND_Y;
            skip_ok_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sequencer
// Purpose  : Drives the cycle counter controls and sequences interrupt entry.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_sequencer
    import cycle_sequencer_pkg::*;
(
    input  logic             clk_ph1,
    input  logic             rst,
    cycle_sequencer_if.slave bus
);

    addr_grp_e w_grp;
    cycle_t    w_last;
    cycle_t    w_fixup;
    logic      w_skip_ok;
    logic      w_inc;
    logic      w_clr;
    logic      w_skip;
    logic      w_nmi_fall;

    logic      force_brk_q, force_brk_d;
    int_src_e  int_src_q, int_src_d;
    logic      nmi_pending_q, nmi_pending_d;
    logic      nmi_prev_q;

    opcode_timing_rom u_rom (
        .ir_i      (bus.IR),
        .grp_o     (w_grp),
        .last_o    (w_last),
        .fixup_o   (w_fixup),
        .skip_ok_o (w_skip_ok)
    );

    always_comb begin
        w_inc  = 1'b0;
        w_clr  = 1'b0;
        w_skip = 1'b0;
        if (bus.rdy) begin
            if (bus.cycle == CYCLE_MAX) begin
                w_inc = 1'b1;
            end else if (w_grp == GRP_BRANCH) begin
                case (bus.cycle)
                    3'd0:    w_inc = 1'b1;
                    3'd1:    if (bus.branch_taken) w_inc = 1'b1; else w_clr = 1'b1;
                    3'd2:    if (bus.page_cross)   w_inc = 1'b1; else w_clr = 1'b1;
                    default: w_clr = 1'b1;
                endcase
            end else if (w_skip_ok && !bus.page_cross && (bus.cycle == w_fixup - 3'd1)) begin
                w_skip = 1'b1;
            end else if (bus.cycle == w_last) begin
                w_clr = 1'b1;
            end else begin
                w_inc = 1'b1;
            end
        end
    end

    assign w_nmi_fall = nmi_prev_q && !bus.nmi_n;

    // Interrupts are only taken on an instruction boundary (a real R_cycle edge).
    always_comb begin
        force_brk_d   = force_brk_q;
        int_src_d     = int_src_q;
        nmi_pending_d = nmi_pending_q;
        if (w_clr) begin
            if (nmi_pending_q) begin
                force_brk_d   = 1'b1;
                int_src_d     = INT_NMI;
                nmi_pending_d = 1'b0;
            end else if (!bus.irq_n && !bus.i_flag) begin
                force_brk_d = 1'b1;
                int_src_d   = INT_IRQ;
            end else begin
                force_brk_d = 1'b0;
                int_src_d   = INT_NONE;
            end
        end else if (bus.cycle == 3'd1) begin
            force_brk_d = 1'b0;
        end
        if (w_nmi_fall) begin
            nmi_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            force_brk_q   <= 1'b1;
            int_src_q     <= INT_RESET;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b1;
        end else begin
            force_brk_q   <= force_brk_d;
            int_src_q     <= int_src_d;
            nmi_pending_q <= nmi_pending_d;
            nmi_prev_q    <= bus.nmi_n;
        end
    end

    assign bus.I_cycle   = w_inc;
    assign bus.R_cycle   = w_clr;
    assign bus.S_cycle   = w_skip;
    assign bus.force_brk = force_brk_q;
    assign bus.int_src   = int_src_q;
    assign bus.sync      = (bus.cycle == 3'd1);

endmodule
`default_nettype wire
